banner_layer: RTL and testbench



---
 rtl/banner_layer_pkg.sv | 46 ++++
 rtl/banner_rom.sv | 51 +++++
 rtl/banner_layer.sv | 174 +++++++++++++++++
 tb/tb_banner_layer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/banner_layer_pkg.sv
// Shared geometry, state encoding, palette and glyph helpers for the banner layer.
package banner_layer_pkg;

  localparam int LEFT = 80;
  localparam int TOP  = 80;
  localparam int MAXX = 512;
  localparam int MAXY = 448;

  typedef enum logic [1:0] {
    BL_IDLE,
    BL_FADE_IN,
    BL_SHOW,
    BL_FADE_OUT
  } bl_state_t;

  localparam logic [3:0] PAL_BORDER    = 4'b1111;
  localparam logic [3:0] PAL_TEXT_BASE = 4'b1000;

  typedef enum logic [2:0] {G_I, G_N, G_T, G_D, G_E, G_A, G_W, G_S} glyph_t;

  // Text colours cycle through 4'b1000..4'b1110; 4'b1111 is reserved for the border.
  function automatic logic [3:0] text_colour(input logic [2:0] msg, input logic [2:0] band,
                                             input logic [2:0] phase);
    logic [2:0] sum;
    logic [3:0] c;
    sum = msg + band + phase;
    c   = {1'b1, sum};
    return (c == PAL_BORDER) ? PAL_TEXT_BASE : c;
  endfunction

  // 3x5 font, top row first, MSB is the leftmost pixel.
  function automatic logic [14:0] glyph_bits(input glyph_t g);
    case (g)
      G_I:     return 15'b111_010_010_010_111;
      G_N:     return 15'b110_101_101_101_101;
      G_T:     return 15'b111_010_010_010_010;
      G_D:     return 15'b110_101_101_101_110;
      G_E:     return 15'b111_100_110_100_111;
      G_A:     return 15'b010_101_111_101_101;
      G_W:     return 15'b101_101_101_111_101;
      G_S:     return 15'b011_100_010_001_110;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/banner_rom.sv
// Combinational glyph ROM: bars on the first/last text rows plus a four-letter word per banner.
module banner_rom
  import banner_layer_pkg::*;
#(
  parameter  int NUM_MSG = 4,
  parameter  int ROWS    = 20,
  localparam int MSG_W   = $clog2(NUM_MSG)
) (
  input  logic [4:0]       row,
  input  logic [4:0]       col,
  input  logic [MSG_W-1:0] select,
  output logic             word
);

  localparam int TEXT_ROW = 7;
  localparam int TEXT_COL = 8;

  logic [11:0]  letters;
  logic         known;
  logic [14:0]  bits;
  glyph_t       letter;
  int unsigned  r, c, sel_i;

  always_comb begin
    letters = '0;
    known   = 1'b1;
    bits    = '0;
    letter  = G_I;
    word    = 1'b0;
    r       = 32'(row);
    c       = 32'(col);
    sel_i   = 32'(select);
    case (sel_i)
      0:       letters = {G_I, G_N, G_I, G_T};
      1:       letters = {G_D, G_E, G_A, G_D};
      2:       letters = {G_W, G_I, G_N, G_S};
      3:       letters = {G_W, G_A, G_I, G_T};
      default: known = 1'b0;
    endcase
    if ((r == 0 || r == ROWS - 1) && c >= 2 && c <= 29) begin
      word = 1'b1;
    end else if (known && r >= TEXT_ROW && r <= TEXT_ROW + 4 && c >= TEXT_COL &&
                 c <= TEXT_COL + 15 && ((c - TEXT_COL) % 4) != 3) begin
      // Letters are 3 cells wide with a 1-cell gap; the first letter sits in the MSBs.
      letter = glyph_t'(letters[(3 - (c - TEXT_COL) / 4) * 3 +: 3]);
      bits   = glyph_bits(letter);
      word   = bits[14 - (r - TEXT_ROW) * 3 - (c - TEXT_COL) % 4];
    end
  end

endmodule

// File: rtl/banner_layer.sv
// Frame-animated border and text banner layer with a 2-cycle registered pixel path.
module banner_layer
  import banner_layer_pkg::*;
#(
  parameter  int BORDER_W     = 72,
  parameter  int GLYPH_SHIFT  = 4,
  parameter  int TEXT_H       = 320,
  parameter  int NUM_MSG      = 4,
  parameter  int BLINK_FRAMES = 32,
  parameter  int PHASE_FRAMES = 8,
  localparam int MSG_W        = $clog2(NUM_MSG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      vcounter,
  input  logic [11:0]      hcounter,
  input  logic             frame_start,
  input  logic             msg_valid,
  input  logic [MSG_W-1:0] msg_sel,
  input  logic             blink_en,
  output logic [3:0]       out
);

  localparam int ROWS = TEXT_H >> GLYPH_SHIFT;
  localparam int RW   = $clog2(ROWS + 1);
  localparam int BW   = $clog2(BLINK_FRAMES) + 1;
  localparam int PW   = (PHASE_FRAMES > 1) ? $clog2(PHASE_FRAMES) : 1;

  bl_state_t        state, state_n;
  logic [MSG_W-1:0] cur_msg, msg_n;
  logic [RW-1:0]    reveal, reveal_n;
  logic [BW-1:0]    blink_cnt, blink_n;
  logic [2:0]       phase;
  logic [PW-1:0]    phase_div;
  logic             keep, text_live, blanked;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BL_IDLE;
      cur_msg   <= '0;
      reveal    <= '0;
      blink_cnt <= '0;
    end else begin
      state     <= state_n;
      cur_msg   <= msg_n;
      reveal    <= reveal_n;
      blink_cnt <= blink_n;
    end
  end

  always_comb begin
    state_n  = state;
    msg_n    = cur_msg;
    reveal_n = reveal;
    blink_n  = blink_cnt;
    keep     = msg_valid && (msg_sel == cur_msg);
    if (frame_start) begin
      case (state)
        BL_IDLE: begin
          if (msg_valid) begin
            msg_n    = msg_sel;
            reveal_n = '0;
            state_n  = BL_FADE_IN;
          end
        end
        BL_FADE_IN: begin
          if (!keep) begin
            state_n = BL_FADE_OUT;
          end else begin
            reveal_n = reveal + RW'(1);
            if (reveal_n == RW'(ROWS)) begin
              state_n = BL_SHOW;
              blink_n = '0;
            end
          end
        end
        BL_SHOW: begin
          if (!keep) state_n = BL_FADE_OUT;
          else       blink_n = blink_cnt + BW'(1);
        end
        BL_FADE_OUT: begin
          // reveal == 0 on entry resolves exactly like the final decrement.
          if (reveal <= RW'(1)) begin
            reveal_n = '0;
            if (msg_valid) begin
              msg_n   = msg_sel;
              state_n = BL_FADE_IN;
            end else begin
              state_n = BL_IDLE;
            end
          end else begin
            reveal_n = reveal - RW'(1);
          end
        end
        default: state_n = BL_IDLE;
      endcase
    end
  end

  always_comb begin
    text_live = (state != BL_IDLE);
    blanked   = (state == BL_SHOW) && blink_en && blink_cnt[BW-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= '0;
      phase_div <= '0;
    end else if (frame_start) begin
      if (phase_div == PW'(PHASE_FRAMES - 1)) begin
        phase_div <= '0;
        phase     <= phase + 3'd1;
      end else begin
        phase_div <= phase_div + PW'(1);
      end
    end
  end

  logic [11:0] hx;
  logic [10:0] vy;
  logic [4:0]  col, row;
  logic        in_px, in_py, in_text, in_ox, in_oy, visible;

  assign hx      = hcounter - 12'(LEFT);
  assign vy      = vcounter - 11'(TOP);
  assign col     = 5'(hx >> GLYPH_SHIFT);
  assign row     = 5'(vy >> GLYPH_SHIFT);
  assign in_px   = (hcounter >= 12'(LEFT)) && (hcounter < 12'(LEFT + MAXX));
  assign in_py   = (vcounter >= 11'(TOP)) && (vcounter < 11'(TOP + MAXY));
  assign in_text = in_px && (vcounter >= 11'(TOP)) && (vcounter < 11'(TOP + TEXT_H));
  assign in_ox   = (hcounter >= 12'(LEFT - BORDER_W)) && (hcounter < 12'(LEFT + MAXX + BORDER_W));
  assign in_oy   = (vcounter >= 11'(TOP - BORDER_W)) && (vcounter < 11'(TOP + MAXY + BORDER_W));
  assign visible = in_text && text_live && (32'(row) < 32'(reveal)) && !blanked;

  logic [4:0] s1_col, s1_row;
  logic       s1_vis, s1_border;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_col    <= '0;
      s1_row    <= '0;
      s1_vis    <= 1'b0;
      s1_border <= 1'b0;
    end else begin
      s1_col    <= col;
      s1_row    <= row;
      s1_vis    <= visible;
      s1_border <= in_ox && in_oy && !(in_px && in_py);
    end
  end

  logic       glyph_bit;
  logic [3:0] colour;

  banner_rom #(
    .NUM_MSG(NUM_MSG),
    .ROWS   (ROWS)
  ) u_rom (
    .row   (s1_row),
    .col   (s1_col),
    .select(cur_msg),
    .word  (glyph_bit)
  );

  assign colour = text_colour(3'(cur_msg), s1_row[4:2], phase);

  always_ff @(posedge clk) begin
    if (rst)                      out <= '0;
    else if (s1_border)           out <= PAL_BORDER;
    else if (s1_vis && glyph_bit) out <= colour;
    else                          out <= '0;
  end

endmodule

// File: tb/tb_banner_layer.sv
// Directed bench for banner_layer: scoreboard queue aligned to the 2-cycle pixel latency.
module tb_banner_layer;
  import banner_layer_pkg::*;

  localparam int BORDER_W     = 72;
  localparam int GLYPH_SHIFT  = 4;
  localparam int TEXT_H       = 320;
  localparam int NUM_MSG      = 4;
  localparam int BLINK_FRAMES = 32;
  localparam int PHASE_FRAMES = 8;
  localparam int MSG_W        = 2;
  localparam int ROWS         = 20;

  localparam int COL_H   = LEFT + 10 * 16 + 7;
  localparam int ROW0_V  = TOP + 3;
  localparam int ROW3_V  = TOP + 3 * 16 + 2;
  localparam int ROW19_V = TOP + 19 * 16 + 5;

  logic             clk;
  logic             rst;
  logic [10:0]      vcounter;
  logic [11:0]      hcounter;
  logic             frame_start;
  logic             msg_valid;
  logic [MSG_W-1:0] msg_sel;
  logic             blink_en;
  logic [3:0]       out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  banner_layer #(
    .BORDER_W    (BORDER_W),
    .GLYPH_SHIFT (GLYPH_SHIFT),
    .TEXT_H      (TEXT_H),
    .NUM_MSG     (NUM_MSG),
    .BLINK_FRAMES(BLINK_FRAMES),
    .PHASE_FRAMES(PHASE_FRAMES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vcounter   (vcounter),
    .hcounter   (hcounter),
    .frame_start(frame_start),
    .msg_valid  (msg_valid),
    .msg_sel    (msg_sel),
    .blink_en   (blink_en),
    .out        (out)
  );

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];
  bit         chk_q[$];
  string      tag_q[$];

  // Reference model of the banner sequencing (0 idle, 1 fade-in, 2 show, 3 fade-out).
  int m_state = 0, m_rev = 0, m_msg = 0, m_blink = 0, nframes = 0;

  task automatic step(input int h, input int v, input bit fs, input bit chk,
                      input logic [3:0] e, input string tag);
    logic [3:0] pe;
    bit         pc;
    string      pt;
    @(negedge clk);
    if (exp_q.size() == 2) begin
      pe = exp_q.pop_front();
      pc = chk_q.pop_front();
      pt = tag_q.pop_front();
      if (pc) begin
        tests++;
        assert (out === pe) else begin
          fails++;
          $error("FAIL %s: out=%b expected=%b", pt, out, pe);
        end
      end
    end
    hcounter    = 12'(h);
    vcounter    = 11'(v);
    frame_start = fs;
    exp_q.push_back(e);
    chk_q.push_back(chk);
    tag_q.push_back(tag);
  endtask

  function automatic logic [3:0] exp_pix(input int h, input int v, input bit lit);
    bit in_play, in_outer;
    int y, c;
    in_play  = h >= LEFT && h < LEFT + MAXX && v >= TOP && v < TOP + MAXY;
    in_outer = h >= LEFT - BORDER_W && h < LEFT + MAXX + BORDER_W &&
               v >= TOP - BORDER_W && v < TOP + MAXY + BORDER_W;
    if (in_outer && !in_play) return 4'hF;
    if (!(in_play && v < TOP + TEXT_H && lit)) return 4'h0;
    y = (v - TOP) / 16;
    if (m_state == 0 || y >= m_rev) return 4'h0;
    if (m_state == 2 && blink_en && ((m_blink / BLINK_FRAMES) % 2) == 1) return 4'h0;
    c = 8 + (m_msg + y / 4 + nframes / PHASE_FRAMES) % 8;
    if (c == 15) c = 8;
    return 4'(c);
  endfunction

  task automatic probe(input int h, input int v, input bit lit, input string tag);
    step(h, v, 1'b0, 1'b1, exp_pix(h, v, lit), tag);
  endtask

  task automatic frame(input bit v, input int sel);
    msg_valid = v;
    msg_sel   = MSG_W'(sel);
    step(0, 0, 1'b1, 1'b0, 4'h0, "frame");
    nframes++;
    case (m_state)
      0: if (v) begin m_msg = sel; m_rev = 0; m_state = 1; end
      1: begin
        if (!v || sel != m_msg) m_state = 3;
        else begin
          m_rev++;
          if (m_rev == ROWS) begin m_state = 2; m_blink = 0; end
        end
      end
      2: if (!v || sel != m_msg) m_state = 3; else m_blink++;
      default: begin
        if (m_rev > 0) m_rev--;
        if (m_rev == 0) begin
          if (v) begin m_msg = sel; m_state = 1; end
          else m_state = 0;
        end
      end
    endcase
  endtask

  initial begin
    rst = 1'b1; hcounter = '0; vcounter = '0; frame_start = 1'b0;
    msg_valid = 1'b1; msg_sel = 2'd3; blink_en = 1'b0;

    for (int i = 0; i < 3; i++)
      step($urandom_range(0, 700), $urandom_range(0, 620), 1'b1, 1'b1, 4'h0, "reset_out");
    step(0, 0, 1'b0, 1'b1, 4'h0, "reset_out");
    rst = 1'b0;
    msg_valid = 1'b0;
    msg_sel = '0;

    probe(LEFT - 1, TOP + 10, 1'b0, "border_left");
    probe(LEFT + MAXX, TOP + 10, 1'b0, "border_right");
    probe(LEFT + MAXX + BORDER_W, TOP + 10, 1'b0, "beyond_border");
    probe(LEFT + 32, TOP - 1, 1'b0, "border_top");
    probe(LEFT + 32, TOP - BORDER_W - 1, 1'b0, "above_border");
    probe(COL_H, ROW0_V, 1'b1, "idle_text");
    probe(COL_H, TOP + TEXT_H, 1'b0, "below_text");

    frame(1'b1, 1);
    probe(COL_H, ROW0_V, 1'b1, "fade_in_start");
    for (int i = 0; i < 20; i++) begin
      frame(1'b1, 1);
      probe(COL_H, ROW0_V, 1'b1, "reveal_row0");
      probe(COL_H, ROW19_V, 1'b1, "reveal_row19");
    end
    probe(COL_H, ROW3_V, 1'b0, "unlit_row");

    blink_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      frame(1'b1, 1);
      probe(COL_H, ROW19_V, 1'b1, "blink_text");
      probe(LEFT - 1, ROW19_V, 1'b0, "blink_border");
    end
    blink_en = 1'b0;

    frame(1'b1, 2);
    probe(COL_H, ROW19_V, 1'b1, "switch_fade_out");
    for (int i = 0; i < 20; i++) begin
      frame(1'b1, 2);
      probe(COL_H, ROW0_V, 1'b1, "switch_row0");
      probe(COL_H, ROW19_V, 1'b1, "switch_row19");
    end
    for (int i = 0; i < 5; i++) begin
      frame(1'b1, 2);
      probe(COL_H, ROW0_V, 1'b1, "refade_in");
    end

    for (int i = 0; i < 6; i++) begin
      frame(1'b0, 2);
      probe(COL_H, ROW0_V, 1'b1, "drop_fade");
    end
    probe(COL_H, ROW0_V, 1'b1, "idle_after_row0");
    probe(COL_H, ROW19_V, 1'b1, "idle_after_row19");

    frame(1'b1, 3);
    for (int i = 0; i < 20; i++) frame(1'b1, 3);
    for (int i = 0; i < 64 && ((nframes / PHASE_FRAMES) % 8) != 0; i++) frame(1'b1, 3);
    step(COL_H, ROW19_V, 1'b0, 1'b1, PAL_TEXT_BASE, "colour_substitute");
    probe(COL_H, ROW0_V, 1'b1, "colour_band0");
    step(LEFT - 1, ROW19_V, 1'b0, 1'b1, PAL_BORDER, "border_left_edge");

    step(0, 0, 1'b0, 1'b0, 4'h0, "flush");
    step(0, 0, 1'b0, 1'b0, 4'h0, "flush");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
